// File: rtl/crossbar_input_queue.sv
// Crossbar input stage: one circular FIFO per requester. Each FIFO exposes its
// head entry to the arbiter, and the granted heads are steered onto registered
// per-output data lanes. A sticky flag records any grant that breaks protocol.

// One requester FIFO holding {data, dst}; pops only when it has an entry.
module crossbar_input_queue_fifo #(
   parameter int DATA_W = 32,
   parameter int DST_W  = 3,
   parameter int DEPTH  = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_vld,
   output logic              push_rdy,
   input  logic [DATA_W-1:0] push_data,
   input  logic [DST_W-1:0]  push_dst,
   input  logic              pop_req,
   output logic              head_vld,
   output logic [DATA_W-1:0] head_data,
   output logic [DST_W-1:0]  head_dst,
   output logic [PW:0]       count
);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0] mem_data;
   logic [DEPTH-1:0][DST_W-1:0]  mem_dst;
   logic [PW-1:0]                rd_ptr, wr_ptr;
   logic                         push, pop;

   // Ready looks only at the stored count, so a same-cycle pop never frees a
   // slot for a push into a full queue.
   assign push_rdy  = (count != FULL);
   assign head_vld  = (count != '0);
   assign push      = push_vld & push_rdy;
   assign pop       = pop_req & head_vld;
   assign head_data = mem_data[rd_ptr];
   assign head_dst  = mem_dst[rd_ptr];

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= push_data;
         mem_dst[wr_ptr]  <= push_dst;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module crossbar_input_queue #(
   parameter int N_IN_PORTS  = 8,
   parameter int N_OUT_PORTS = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   localparam int DST_W      = (N_OUT_PORTS > 1) ? $clog2(N_OUT_PORTS) : 1,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_IN_PORTS-1:0]                  in_vld,
   output logic [N_IN_PORTS-1:0]                  in_rdy,
   input  logic [N_IN_PORTS-1:0][DATA_W-1:0]      in_data,
   input  logic [N_IN_PORTS-1:0][DST_W-1:0]       in_dst,
   output logic [N_IN_PORTS-1:0]                  req,
   output logic [N_IN_PORTS-1:0][DST_W-1:0]       req_out_port,
   input  logic [N_IN_PORTS-1:0]                  grant,
   input  logic [N_OUT_PORTS-1:0][N_IN_PORTS-1:0] detailed_grant,
   output logic [N_OUT_PORTS-1:0]                 out_vld,
   output logic [N_OUT_PORTS-1:0][DATA_W-1:0]     out_data,
   output logic [N_IN_PORTS-1:0][CNT_W-1:0]       occupancy,
   output logic                                   err
);
   logic [N_IN_PORTS-1:0][DATA_W-1:0]  head_data;
   logic [N_OUT_PORTS-1:0]             sel_vld;
   logic [N_OUT_PORTS-1:0][DATA_W-1:0] sel_data;
   logic [N_IN_PORTS-1:0]              gcol;
   logic                               err_now;

   for (genvar i = 0; i < N_IN_PORTS; i++) begin : g_q
      crossbar_input_queue_fifo #(.DATA_W(DATA_W), .DST_W(DST_W), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push_vld  (in_vld[i]),
         .push_rdy  (in_rdy[i]),
         .push_data (in_data[i]),
         .push_dst  (in_dst[i]),
         .pop_req   (grant[i]),
         .head_vld  (req[i]),
         .head_data (head_data[i]),
         .head_dst  (req_out_port[i]),
         .count     (occupancy[i])
      );
   end

   // Per-output AND-OR mux of the granted heads (rows are one-hot or zero).
   always_comb begin
      sel_vld  = '0;
      sel_data = '0;
      for (int o = 0; o < N_OUT_PORTS; o++) begin
         sel_vld[o] = |detailed_grant[o];
         for (int i = 0; i < N_IN_PORTS; i++)
            if (detailed_grant[o][i]) sel_data[o] = sel_data[o] | head_data[i];
      end
   end

   // Flag grants to empty queues, grant/detailed_grant disagreement,
   // misrouted grants and rows with more than one requester.
   always_comb begin
      err_now = 1'b0;
      gcol    = '0;
      for (int o = 0; o < N_OUT_PORTS; o++) begin
         if ((detailed_grant[o] & (detailed_grant[o] - N_IN_PORTS'(1))) != '0) err_now = 1'b1;
         for (int i = 0; i < N_IN_PORTS; i++) begin
            if (detailed_grant[o][i]) begin
               gcol[i] = 1'b1;
               if (req_out_port[i] != DST_W'(o)) err_now = 1'b1;
            end
         end
      end
      for (int i = 0; i < N_IN_PORTS; i++) begin
         if (grant[i] && !req[i]) err_now = 1'b1;
         if (grant[i] != gcol[i]) err_now = 1'b1;
      end
   end

   // Output lanes: valid every cycle, data only on a transfer so it holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld  <= '0;
         out_data <= '0;
      end else begin
         out_vld <= sel_vld;
         for (int o = 0; o < N_OUT_PORTS; o++)
            if (sel_vld[o]) out_data[o] <= sel_data[o];
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err <= 1'b0;
      else      err <= err | err_now;
   end
endmodule

// File: tb/tb_crossbar_input_queue.sv
// Bench for crossbar_input_queue: queue-based reference model plus an
// output scoreboard drained by an independent monitor.
module tb_crossbar_input_queue;
   localparam int NI = 8, NO = 8, DW = 32, DEPTH = 4, SW = 3, OW = 3;

   logic clk = 1'b0, rst = 1'b0;
   logic [NI-1:0]         in_vld, in_rdy, req, grant;
   logic [NI-1:0][DW-1:0] in_data;
   logic [NI-1:0][SW-1:0] in_dst, req_out_port;
   logic [NO-1:0][NI-1:0] detailed_grant;
   logic [NO-1:0]         out_vld;
   logic [NO-1:0][DW-1:0] out_data;
   logic [NI-1:0][OW-1:0] occupancy;
   logic                  err;

   always #5 clk = ~clk;

   crossbar_input_queue #(.N_IN_PORTS(NI), .N_OUT_PORTS(NO), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .in_dst(in_dst), .req(req), .req_out_port(req_out_port), .grant(grant),
      .detailed_grant(detailed_grant), .out_vld(out_vld), .out_data(out_data),
      .occupancy(occupancy), .err(err));

   typedef struct packed {logic [DW-1:0] data; logic [SW-1:0] dst;} ent_t;
   ent_t          mq[NI][$];
   logic [DW-1:0] sb[NO][$];
   logic [DW-1:0] last_data[NO];
   logic          exp_err;
   bit            mon_en;
   int            n_chk, n_fail;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: every presented transfer must match the oldest expectation;
   // idle lanes must hold their last data.
   always @(negedge clk) if (mon_en) begin
      for (int o = 0; o < NO; o++) begin
         if (out_vld[o] === 1'b1) begin
            if (sb[o].size() == 0) chk($sformatf("unexpected_out_vld[%0d]", o), 1, 0);
            else chk($sformatf("out_data[%0d]", o), out_data[o], sb[o].pop_front());
            last_data[o] = out_data[o];
         end else begin
            chk($sformatf("out_vld[%0d]", o), out_vld[o], 0);
            chk($sformatf("out_data_hold[%0d]", o), out_data[o], last_data[o]);
         end
      end
   end

   // Compare visible state with the model, queue expected transfers, then
   // advance the model by one clock edge.
   function automatic void predict();
      logic e;
      logic [NI-1:0] col;
      logic [NI-1:0] do_push;
      e = 1'b0;
      col = '0;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("occupancy[%0d]", i), occupancy[i], mq[i].size());
         chk($sformatf("in_rdy[%0d]", i), in_rdy[i], mq[i].size() < DEPTH);
         chk($sformatf("req[%0d]", i), req[i], mq[i].size() != 0);
         if (mq[i].size() != 0) chk($sformatf("req_out_port[%0d]", i), req_out_port[i], mq[i][0].dst);
      end
      chk("err", err, exp_err);
      for (int o = 0; o < NO; o++) begin
         if ($countones(detailed_grant[o]) > 1) e = 1'b1;
         for (int i = 0; i < NI; i++) if (detailed_grant[o][i]) begin
            col[i] = 1'b1;
            if (mq[i].size() == 0 || mq[i][0].dst != o) e = 1'b1;
            else if ($countones(detailed_grant[o]) == 1) sb[o].push_back(mq[i][0].data);
         end
      end
      for (int i = 0; i < NI; i++) begin
         if (grant[i] && mq[i].size() == 0) e = 1'b1;
         if (grant[i] != col[i]) e = 1'b1;
         do_push[i] = in_vld[i] && mq[i].size() < DEPTH;
      end
      for (int i = 0; i < NI; i++) begin
         if (grant[i] && mq[i].size() != 0) void'(mq[i].pop_front());
         if (do_push[i]) mq[i].push_back('{in_data[i], in_dst[i]});
      end
      exp_err = exp_err | e;
   endfunction

   task automatic tick();
      @(negedge clk); #1;
      predict();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_vld = '0; grant = '0; detailed_grant = '0;
   endtask

   task automatic give(input int i);
      grant[i] = 1'b1;
      detailed_grant[mq[i][0].dst][i] = 1'b1;
   endtask

   // Legal random grants: at most one requester per output, thr/4 chance each.
   task automatic rand_grants(input int thr);
      logic [NO-1:0] used;
      int off;
      used = '0; grant = '0; detailed_grant = '0;
      off = $urandom_range(0, NI-1);
      for (int k = 0; k < NI; k++) begin
         int i;
         i = (k + off) % NI;
         if (mq[i].size() != 0 && !used[mq[i][0].dst] && $urandom_range(0, 3) < thr) begin
            used[mq[i][0].dst] = 1'b1;
            give(i);
         end
      end
   endtask

   task automatic push1(input int i, input logic [DW-1:0] d, input logic [SW-1:0] t);
      in_vld[i] = 1'b1; in_data[i] = d; in_dst[i] = t;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NI; i++) if (mq[i].size() != 0) return 0;
      return 1;
   endfunction

   // Assert reset between edges and check its effect before any edge.
   task automatic do_reset();
      idle();
      #1 rst = 1'b0;
      #1;
      chk("rst_req", req, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_rdy", in_rdy, {NI{1'b1}});
      chk("rst_err", err, 0);
      chk("rst_out_data", out_data, 0);
      for (int i = 0; i < NI; i++) mq[i].delete();
      for (int o = 0; o < NO; o++) begin sb[o].delete(); last_data[o] = '0; end
      exp_err = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0; n_fail = 0; exp_err = 1'b0; mon_en = 1'b0;
      in_data = '0; in_dst = '0;
      for (int o = 0; o < NO; o++) last_data[o] = '0;
      idle();
      #3;
      chk("reset_in_rdy", in_rdy, {NI{1'b1}});
      chk("reset_req", req, 0);
      chk("reset_occupancy", occupancy, 0);
      chk("reset_out_vld", out_vld, 0);
      chk("reset_err", err, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      mon_en = 1'b1;

      // Fill and drain port 0.
      for (int k = 0; k < 4; k++) begin idle(); push1(0, 32'hA0 + k, 3'd5); tick(); end
      idle();
      chk("fill_occ0", occupancy[0], 4);
      chk("fill_rdy0", in_rdy[0], 0);
      for (int k = 0; k < 4; k++) begin idle(); give(0); tick(); end
      idle(); tick(); tick();
      chk("drain_occ0", occupancy[0], 0);
      chk("drain_sb5", sb[5].size(), 0);

      // Wrap-around on port 2.
      for (int k = 0; k < 3; k++) begin idle(); push1(2, 32'hB0 + k, SW'(k)); tick(); end
      for (int k = 0; k < 3; k++) begin idle(); give(2); tick(); end
      for (int k = 0; k < 4; k++) begin idle(); push1(2, 32'hC0 + k, SW'(7 - k)); tick(); end
      idle();
      chk("wrap_occ2", occupancy[2], 4);
      for (int k = 0; k < 4; k++) begin idle(); give(2); tick(); end
      idle(); tick();
      chk("wrap_err", err, 0);

      // Simultaneous push and pop at occupancy 1 on port 1.
      idle(); push1(1, 32'h11, 3'd2); tick();
      idle(); push1(1, 32'h55, 3'd6); give(1); tick();
      idle();
      chk("pushpop_occ1", occupancy[1], 1);
      chk("pushpop_dst1", req_out_port[1], 6);
      give(1); tick(); idle(); tick();

      // Full queue with pop: push rejected.
      for (int k = 0; k < 4; k++) begin idle(); push1(4, 32'hD0 + k, 3'd3); tick(); end
      idle(); push1(4, 32'h99, 3'd1); give(4);
      chk("full_rdy4", in_rdy[4], 0);
      tick(); idle();
      chk("full_occ4", occupancy[4], 3);
      for (int k = 0; k < 3; k++) begin idle(); give(4); tick(); end
      idle(); tick();

      // Random traffic with legal grants.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) begin
            in_vld[i] = ($urandom_range(0, 2) != 0);
            in_data[i] = $urandom;
            in_dst[i] = SW'($urandom_range(0, NO-1));
         end
         rand_grants(2);
         tick();
      end
      in_vld = '0;
      for (int c = 0; c < 100 && !all_empty(); c++) begin rand_grants(4); tick(); end
      idle(); tick();
      chk("random_drained", all_empty(), 1);
      chk("random_err", err, 0);

      // Protocol error: grant to empty queue 3.
      idle(); grant[3] = 1'b1; tick();
      idle();
      chk("perr_err", err, 1);
      chk("perr_occ3", occupancy[3], 0);
      tick(); tick();
      chk("perr_sticky", err, 1);

      // Reset mid-stream with two entries per port.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NI; i++) push1(i, $urandom, SW'($urandom_range(0, NO-1)));
         tick();
      end
      idle(); tick();
      chk("pre_rst_occ7", occupancy[7], 2);
      do_reset();

      // First push is accepted on the first edge after reset release.
      idle(); push1(0, 32'h77, 3'd1); tick();
      idle();
      chk("post_rst_occ0", occupancy[0], 1);
      give(0); tick(); idle(); tick(); tick();
      for (int o = 0; o < NO; o++) chk($sformatf("sb_empty[%0d]", o), sb[o].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
